// File: rtl/prog_clk_divider_pkg.sv
// prog_clk_divider_pkg: shared defaults and helpers for the divide-by-N timing generator
//   DEFAULT_WIDTH     - default divisor/phase width
//   DEFAULT_RESET_DIV - divisor in use out of reset
//   hi_threshold(d)   - number of high phases per period, (d+1)/2, without overflow
package prog_clk_divider_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_RESET_DIV = 3;

    function automatic logic [32:0] hi_threshold(input logic [31:0] d);
        return ({1'b0, d} + 33'd1) >> 1;
    endfunction

endpackage

// File: rtl/prog_clk_divider_div_shadow_reg.sv
// div_shadow_reg: shadowed divisor with zero-coercion and same-cycle apply bypass
//   clk, reset_n      - clock, async active-low reset
//   div_in, div_load  - new divisor and its capture strobe
//   apply             - period boundary (wrap or clr): shadow becomes active
//   div_active        - divisor currently in use
//   load_pending      - shadow holds a divisor not yet applied
module div_shadow_reg #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    input  logic             apply,
    output logic [WIDTH-1:0] div_active,
    output logic             load_pending
);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;
    logic             r_pending;
    logic [WIDTH-1:0] w_din;

    // a zero divisor is meaningless; treat it as divide-by-1
    assign w_din = (div_in == '0) ? WIDTH'(1) : div_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow  <= '0;
            r_active  <= WIDTH'(RESET_DIV);
            r_pending <= 1'b0;
        end else if (apply) begin
            // a load arriving on the boundary itself wins over the shadow
            r_active  <= div_load ? w_din : (r_pending ? r_shadow : r_active);
            r_pending <= 1'b0;
        end else if (div_load) begin
            r_shadow  <= w_din;
            r_pending <= 1'b1;
        end
    end

    assign div_active   = r_active;
    assign load_pending = r_pending;

endmodule

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: programmable divide-by-N tick / square-wave / phase generator
//   clk, reset_n      - clock, async active-low reset
//   en                - count enable, low freezes phase and sq_out
//   clr               - sync restart: phase to 0, pending divisor applied
//   div_in, div_load  - new divisor and its capture strobe
//   tick              - (phase==0) && en
//   sq_out            - registered, high while phase < (D+1)/2
//   phase             - current count 0..D-1
//   div_active        - divisor in use (D)
//   load_pending      - a captured divisor awaits the next boundary
module prog_clk_divider
    import prog_clk_divider_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int RESET_DIV = DEFAULT_RESET_DIV
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             tick,
    output logic             sq_out,
    output logic [WIDTH-1:0] phase,
    output logic [WIDTH-1:0] div_active,
    output logic             load_pending
);

    logic [WIDTH-1:0] r_phase;
    logic             r_sq;
    logic [WIDTH-1:0] w_div;
    logic [WIDTH-1:0] w_phase_inc;
    logic [WIDTH:0]   w_thresh;
    logic             w_wrap;
    logic             w_apply;
    logic             w_next_hi;

    div_shadow_reg #(
        .WIDTH    (WIDTH),
        .RESET_DIV(RESET_DIV)
    ) u_shadow (
        .clk         (clk),
        .reset_n     (reset_n),
        .div_in      (div_in),
        .div_load    (div_load),
        .apply       (w_apply),
        .div_active  (w_div),
        .load_pending(load_pending)
    );

    assign w_phase_inc = r_phase + WIDTH'(1);
    assign w_thresh    = (WIDTH+1)'(hi_threshold(32'(w_div)));
    assign w_wrap      = en && (r_phase == w_div - WIDTH'(1));
    assign w_apply     = w_wrap || clr;
    // sq_out is registered, so compute the level belonging to the next phase
    assign w_next_hi   = {1'b0, w_phase_inc} < w_thresh;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
            r_sq    <= 1'b1;
        end else if (w_apply) begin
            r_phase <= '0;
            r_sq    <= 1'b1;
        end else if (en) begin
            r_phase <= w_phase_inc;
            r_sq    <= w_next_hi;
        end
    end

    assign tick       = (r_phase == '0) && en;
    assign sq_out     = r_sq;
    assign phase      = r_phase;
    assign div_active = w_div;

endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: directed scoreboard bench for prog_clk_divider
module tb_prog_clk_divider;

    typedef struct packed {
        logic       t;
        logic       s;
        logic [7:0] ph;
        logic [7:0] d;
        logic       p;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] div_in = 8'd0;
    logic       div_load = 1'b0;
    logic       tick, sq_out, load_pending;
    logic [7:0] phase, div_active;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;
    logic done = 1'b0;

    prog_clk_divider dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .clr         (clr),
        .div_in      (div_in),
        .div_load    (div_load),
        .tick        (tick),
        .sq_out      (sq_out),
        .phase       (phase),
        .div_active  (div_active),
        .load_pending(load_pending)
    );

    always #5 clk = ~clk;

    // drive inputs just after the falling edge and push what the outputs must show this cycle
    task automatic step(input logic rn, input logic e, input logic c, input logic ld,
                        input logic [7:0] din, input logic et, input logic es,
                        input logic [7:0] eph, input logic [7:0] ed, input logic ep);
        exp_t x;
        @(negedge clk);
        #1;
        reset_n  = rn;
        en       = e;
        clr      = c;
        div_load = ld;
        div_in   = din;
        x.t = et; x.s = es; x.ph = eph; x.d = ed; x.p = ep;
        q.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL step %0d %s: got %0d, expected %0d", step_no, name, act, req);
        end
    endtask

    // monitor: outputs are presented every cycle; compare mid-low-phase against the scoreboard
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("tick", int'(tick), int'(x.t));
                chk("sq_out", int'(sq_out), int'(x.s));
                chk("phase", int'(phase), int'(x.ph));
                chk("div_active", int'(div_active), int'(x.d));
                chk("load_pending", int'(load_pending), int'(x.p));
                step_no++;
            end
        end
    end

    initial begin
        //   rn e  c  ld din   tick sq ph d  pend
        step(0, 1, 0, 0, 8'd0, 1, 1, 0, 3, 0);   // held in reset, tick follows en
        step(1, 1, 0, 0, 8'd0, 1, 1, 0, 3, 0);
        step(1, 1, 0, 0, 8'd0, 0, 1, 1, 3, 0);
        step(1, 1, 0, 0, 8'd0, 0, 0, 2, 3, 0);
        step(1, 1, 0, 0, 8'd0, 1, 1, 0, 3, 0);
        step(1, 1, 0, 1, 8'd5, 0, 1, 1, 3, 0);   // load 5 at phase 1
        step(1, 1, 0, 0, 8'd0, 0, 0, 2, 3, 1);
        step(1, 1, 0, 0, 8'd0, 1, 1, 0, 5, 0);   // D=5: sq 1,1,1,0,0
        step(1, 1, 0, 0, 8'd0, 0, 1, 1, 5, 0);
        step(1, 1, 0, 0, 8'd0, 0, 1, 2, 5, 0);
        step(1, 1, 0, 0, 8'd0, 0, 0, 3, 5, 0);
        step(1, 1, 0, 1, 8'd2, 0, 0, 4, 5, 0);   // load 2 on the wrap: bypass
        step(1, 1, 0, 0, 8'd0, 1, 1, 0, 2, 0);
        step(1, 1, 0, 0, 8'd0, 0, 0, 1, 2, 0);
        step(1, 1, 0, 1, 8'd0, 1, 1, 0, 2, 0);   // load 0 -> coerced to 1
        step(1, 1, 0, 0, 8'd0, 0, 0, 1, 2, 1);
        step(1, 1, 0, 0, 8'd0, 1, 1, 0, 1, 0);   // D=1: tick and sq stay high
        step(1, 1, 0, 1, 8'd8, 1, 1, 0, 1, 0);   // bypass load 8 (every cycle wraps)
        step(1, 1, 0, 0, 8'd0, 1, 1, 0, 8, 0);
        step(1, 1, 0, 1, 8'd7, 0, 1, 1, 8, 0);   // load 7
        step(1, 1, 0, 1, 8'd4, 0, 1, 2, 8, 1);   // load 4 overwrites
        step(1, 0, 0, 0, 8'd0, 0, 1, 3, 8, 1);   // en low: frozen, no tick
        step(1, 0, 0, 0, 8'd0, 0, 1, 3, 8, 1);
        step(1, 0, 0, 0, 8'd0, 0, 1, 3, 8, 1);
        step(1, 0, 0, 0, 8'd0, 0, 1, 3, 8, 1);
        step(1, 0, 1, 0, 8'd0, 0, 1, 3, 8, 1);   // clr with en low applies 4
        step(1, 1, 0, 0, 8'd0, 1, 1, 0, 4, 0);
        step(1, 1, 0, 1, 8'd6, 0, 1, 1, 4, 0);   // load 6, will be discarded by reset
        step(1, 1, 0, 0, 8'd0, 0, 0, 2, 4, 1);
        step(0, 1, 0, 0, 8'd0, 1, 1, 0, 3, 0);   // async reset mid-period, no clk edge yet
        step(1, 1, 0, 0, 8'd0, 1, 1, 0, 3, 0);
        step(1, 1, 0, 0, 8'd0, 0, 1, 1, 3, 0);
        repeat (3) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL timeout: bench did not finish, expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
